// File: rtl/plot_fifo_writer_if.sv
// plot_fifo_writer_if: pixel request and framebuffer write signals for plot_fifo_writer.
interface plot_fifo_writer_if;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_plot;
    logic        in_ready;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_wren;
    logic        mem_ack;
    logic [5:0]  count;
    logic        dropped;
    modport master (
        output in_x, in_y, in_colour, in_plot, mem_ack,
        input  in_ready, mem_addr, mem_data, mem_wren, count, dropped
    );
    modport slave (
        input  in_x, in_y, in_colour, in_plot, mem_ack,
        output in_ready, mem_addr, mem_data, mem_wren, count, dropped
    );
endinterface

// File: rtl/plot_fifo_writer.sv
// plot_fifo_writer: pixel FIFO draining into a framebuffer write port held until acked.
// Define PLOT_FIFO_CLIP_EN to discard off-screen pixels and pulse dropped instead.
module plot_fifo_writer #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input logic              clk,
    input logic              rst_n,
    plot_fifo_writer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, WRITE} state_t;
    state_t        state_q;
    logic [14:0]   addr_mem [DEPTH];
    logic [2:0]    col_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [5:0]    count_q;
    logic [14:0]   mem_addr_q, in_addr;
    logic [2:0]    mem_data_q;
    logic          mem_wren_q, dropped_q, clip, accept, push, pop;
    assign in_addr = 15'(32'(bus.in_y) * 32'(SCREEN_W) + 32'(bus.in_x));
`ifdef PLOT_FIFO_CLIP_EN
    assign clip = ({24'd0, bus.in_x} >= 32'(SCREEN_W)) || ({25'd0, bus.in_y} >= 32'(SCREEN_H));
`else
    assign clip = 1'b0;
`endif
    assign bus.in_ready = count_q != 6'(DEPTH);
    assign accept       = bus.in_plot && bus.in_ready;
    assign push         = accept && !clip;
    assign pop          = state_q == WRITE && bus.mem_ack;
    assign rd_nxt       = rd_ptr_q + 1'b1;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.mem_wren = mem_wren_q;
    assign bus.count    = count_q;
    assign bus.dropped  = dropped_q;
    always_ff @(posedge clk)
        if (push) begin
            addr_mem[wr_ptr_q] <= in_addr;
            col_mem[wr_ptr_q]  <= bus.in_colour;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wren_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_nxt;
            count_q   <= count_q + {5'd0, push} - {5'd0, pop};
            dropped_q <= accept && clip;
            if (state_q == IDLE) begin
                if (count_q != '0) begin
                    state_q    <= WRITE;
                    mem_wren_q <= 1'b1;
                    mem_addr_q <= addr_mem[rd_ptr_q];
                    mem_data_q <= col_mem[rd_ptr_q];
                end
            end else if (bus.mem_ack) begin
                // with a single entry left, a same-cycle push becomes the next head directly
                if (count_q > 6'd1) begin
                    mem_addr_q <= addr_mem[rd_nxt];
                    mem_data_q <= col_mem[rd_nxt];
                end else if (push) begin
                    mem_addr_q <= in_addr;
                    mem_data_q <= bus.in_colour;
                end else begin
                    state_q    <= IDLE;
                    mem_wren_q <= 1'b0;
                end
            end
        end
endmodule

// File: tb/tb_plot_fifo_writer.sv
// tb_plot_fifo_writer: directed checks of plot_fifo_writer with hand-computed expectations.
module tb_plot_fifo_writer;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int errors = 0;
    plot_fifo_writer_if bus();
    plot_fifo_writer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input int x, input int y, input int c, input logic p);
        bus.in_x      = 8'(x);
        bus.in_y      = 7'(y);
        bus.in_colour = 3'(c);
        bus.in_plot   = p;
    endtask
    initial begin
        int any_wr, bad, written, k, maxc;
        rst_n = 1'b0;
        bus.mem_ack = 1'b0;
        drive(0, 0, 0, 1'b0);
        #3;
        chk("rst_wren", bus.mem_wren, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_data", bus.mem_data, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_drop", bus.dropped, 0);
        chk("rst_ready", bus.in_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        // single pixel
        bus.mem_ack = 1'b1;
        drive(5, 2, 3, 1'b1);
        step();
        drive(0, 0, 0, 1'b0);
        chk("one_count", bus.count, 1);
        chk("one_lat", bus.mem_wren, 0);
        step();
        chk("one_wren", bus.mem_wren, 1);
        chk("one_addr", bus.mem_addr, 325);
        chk("one_data", bus.mem_data, 3);
        step();
        chk("one_done", bus.mem_wren, 0);
        chk("one_empty", bus.count, 0);
        // fill under backpressure, then drain back-to-back
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(i, 1, i, 1'b1);
            chk("fill_ready", bus.in_ready, int'(i < 8));
            step();
        end
        drive(0, 0, 0, 1'b0);
        chk("fill_count", bus.count, 8);
        chk("fill_ready_full", bus.in_ready, 0);
        chk("fill_wren", bus.mem_wren, 1);
        chk("fill_head", bus.mem_addr, 160);
        step();
        chk("fill_hold", bus.mem_addr, 160);
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_wren", bus.mem_wren, 1);
            chk("drain_addr", bus.mem_addr, 160 + i);
            chk("drain_data", bus.mem_data, i);
            step();
        end
        chk("drain_idle", bus.mem_wren, 0);
        chk("drain_count", bus.count, 0);
        // corner address
        drive(159, 119, 7, 1'b1);
        step();
        drive(0, 0, 0, 1'b0);
        step();
        chk("corner_wren", bus.mem_wren, 1);
        chk("corner_addr", bus.mem_addr, 19199);
        chk("corner_data", bus.mem_data, 7);
        step();
        chk("corner_done", bus.mem_wren, 0);
        // off-screen column
        drive(160, 0, 5, 1'b1);
        step();
        drive(0, 0, 0, 1'b0);
`ifdef PLOT_FIFO_CLIP_EN
        chk("clip_drop", bus.dropped, 1);
        chk("clip_count", bus.count, 0);
        step();
        chk("clip_drop_end", bus.dropped, 0);
        chk("clip_nowr", bus.mem_wren, 0);
        step();
        chk("clip_nowr2", bus.mem_wren, 0);
`else
        chk("noclip_count", bus.count, 1);
        chk("noclip_drop", bus.dropped, 0);
        step();
        chk("noclip_wren", bus.mem_wren, 1);
        chk("noclip_addr", bus.mem_addr, 160);
        step();
        chk("noclip_done", bus.mem_wren, 0);
`endif
        // asynchronous reset in the middle of a write
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(10 + i, 3, i, 1'b1);
            step();
        end
        drive(0, 0, 0, 1'b0);
        step();
        chk("mid_count", bus.count, 4);
        chk("mid_wren", bus.mem_wren, 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_wren", bus.mem_wren, 0);
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_ready", bus.in_ready, 1);
        chk("mid_rst_addr", bus.mem_addr, 0);
        step();
        rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        any_wr = 0;
        repeat (6) begin
            step();
            if (bus.mem_wren) any_wr = 1;
        end
        chk("mid_no_writes", any_wr, 0);
        chk("mid_post_count", bus.count, 0);
        // full-screen row-major stream with ack held high
        bad = 0;
        written = 0;
        k = 0;
        maxc = 0;
        for (int c = 0; c < 40000 && written < 19200; c++) begin
            drive(k % 160, k / 160, k, (k < 19200) && (bus.count == 0 || bus.mem_wren));
            if (bus.in_plot && bus.in_ready) k++;
            step();
            if (bus.mem_wren) begin
                if (bus.mem_addr != 15'(written)) bad++;
                written++;
            end
            if (int'(bus.count) > maxc) maxc = bus.count;
        end
        drive(0, 0, 0, 1'b0);
        step();
        chk("stream_written", written, 19200);
        chk("stream_order_bad", bad, 0);
        chk("stream_max_count", maxc, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
